ray_frame_scheduler: RTL and testbench

Per-frame sequencer for the raycasting datapath. On each video frame start it latches a player/camera state snapshot. It then issues one ray job per screen column as an AXI-stream into the DDA-in FIFO. It waits for the transformation stage to report the last ray pixel written, then issues a frame-buffer swap aligned to the video last-pixel strobe.

---
 rtl/ray_frame_scheduler.sv | 121 ++++++++++++
 tb/tb_ray_frame_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_frame_scheduler.sv
// Per-frame ray job sequencer: snapshots camera state on frame start, streams one
// job per screen column, then waits for render completion and a last-pixel-aligned swap.
module ray_frame_scheduler #(
    parameter int N_COLS         = 320,
    parameter int COL_W          = 9,
    parameter int STATE_W        = 64,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_in,
    input  logic                     frame_trigger_in,
    input  logic                     video_last_pixel_in,
    input  logic [STATE_W-1:0]       state_in,
    output logic                     m_axis_tvalid_out,
    input  logic                     m_axis_tready_in,
    output logic [COL_W+STATE_W-1:0] m_axis_tdata_out,
    output logic                     m_axis_tlast_out,
    input  logic                     render_done_in,
    output logic                     swap_out,
    output logic                     busy_out,
    output logic [7:0]               frame_drop_count_out,
    output logic                     timeout_out
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        WAIT_SWAP = 2'd3
    } state_t;

    state_t               state_reg;
    logic [COL_W-1:0]     col_reg;
    logic [STATE_W-1:0]   snapshot_reg;
    logic [WD_W-1:0]      watchdog_reg;
    logic                 tvalid_reg;
    logic                 tlast_reg;
    logic                 swap_reg;
    logic                 timeout_reg;
    logic [7:0]           drop_reg;
    logic [COL_W-1:0]     col_next;

    assign col_next = col_reg + COL_W'(1);

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            col_reg      <= '0;
            snapshot_reg <= '0;
            watchdog_reg <= '0;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
            swap_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            drop_reg     <= 8'd0;
        end else begin
            swap_reg    <= 1'b0;
            timeout_reg <= 1'b0;

            // Triggers that arrive mid-frame are dropped, not queued.
            if (frame_trigger_in && state_reg != IDLE && drop_reg != 8'hFF)
                drop_reg <= drop_reg + 8'd1;

            case (state_reg)
                IDLE: begin
                    if (frame_trigger_in) begin
                        snapshot_reg <= state_in;
                        col_reg      <= '0;
                        tlast_reg    <= (LAST_COL == '0);
                        tvalid_reg   <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // tvalid is always high here, so tready alone marks a handshake.
                    if (m_axis_tready_in) begin
                        if (col_reg == LAST_COL) begin
                            tvalid_reg   <= 1'b0;
                            tlast_reg    <= 1'b0;
                            watchdog_reg <= '0;
                            state_reg    <= WAIT_DONE;
                        end else begin
                            col_reg   <= col_next;
                            tlast_reg <= (col_next == LAST_COL);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (render_done_in) begin
                        state_reg <= WAIT_SWAP;
                    end else if (watchdog_reg == WD_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        watchdog_reg <= watchdog_reg + WD_W'(1);
                    end
                end
                WAIT_SWAP: begin
                    if (video_last_pixel_in) begin
                        swap_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_axis_tvalid_out    = tvalid_reg;
    assign m_axis_tdata_out     = {col_reg, snapshot_reg};
    assign m_axis_tlast_out     = tlast_reg;
    assign swap_out             = swap_reg;
    assign timeout_out          = timeout_reg;
    assign frame_drop_count_out = drop_reg;
    assign busy_out             = (state_reg != IDLE);

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed bench for ray_frame_scheduler with a 4-column frame and 16-cycle watchdog.
module tb_ray_frame_scheduler;

    localparam int N_COLS  = 4;
    localparam int COL_W   = 9;
    localparam int STATE_W = 64;
    localparam int TMO     = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     trigger;
    logic                     last_pixel;
    logic [STATE_W-1:0]       state_in;
    logic                     tvalid;
    logic                     tready;
    logic [COL_W+STATE_W-1:0] tdata;
    logic                     tlast;
    logic                     render_done;
    logic                     swap;
    logic                     busy;
    logic [7:0]               drops;
    logic                     timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ray_frame_scheduler #(
        .N_COLS(N_COLS), .COL_W(COL_W), .STATE_W(STATE_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pixel_clk_in(clk),
        .rst_in(rst),
        .frame_trigger_in(trigger),
        .video_last_pixel_in(last_pixel),
        .state_in(state_in),
        .m_axis_tvalid_out(tvalid),
        .m_axis_tready_in(tready),
        .m_axis_tdata_out(tdata),
        .m_axis_tlast_out(tlast),
        .render_done_in(render_done),
        .swap_out(swap),
        .busy_out(busy),
        .frame_drop_count_out(drops),
        .timeout_out(timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger = 1'b0; last_pixel = 1'b0; state_in = '0;
        tready = 1'b1; render_done = 1'b0;
        #3;
        n_cmp++;
        if ({tvalid, tlast, swap, busy, timeout, drops} !== 13'd0 || tdata !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b l=%b s=%b b=%b t=%b d=%0d data=%h, want all zero",
                     tvalid, tlast, swap, busy, timeout, drops, tdata);
        end
        step(); step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b tvalid=%b, want 0 0", busy, tvalid);
        end
        $display("reset: done");
    endtask

    task automatic test_issue();
        logic [COL_W+STATE_W-1:0] exp;
        trigger = 1'b1; state_in = 64'hA5;
        step();
        trigger = 1'b0;
        for (int c = 0; c < N_COLS; c++) begin
            exp = {c[COL_W-1:0], 64'hA5};
            n_cmp++;
            if (tvalid !== 1'b1 || tdata !== exp || tlast !== (c == N_COLS - 1)) begin
                n_err++;
                $display("FAIL issue_beat%0d: got v=%b data=%h last=%b, want v=1 data=%h last=%b",
                         c, tvalid, tdata, tlast, exp, (c == N_COLS - 1));
            end
            $display("issue: beat col=%0d data=%h last=%b", c, tdata, tlast);
            step();
        end
        n_cmp++;
        if (tvalid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL issue_end: got tvalid=%b busy=%b, want 0 1", tvalid, busy);
        end
    endtask

    task automatic test_swap();
        render_done = 1'b1; last_pixel = 1'b1;
        step();
        render_done = 1'b0; last_pixel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (swap !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL swap_wait%0d: got swap=%b busy=%b, want 0 1", i, swap, busy);
            end
            step();
        end
        last_pixel = 1'b1;
        step();
        last_pixel = 1'b0;
        n_cmp++;
        if (swap !== 1'b1 || busy !== 1'b0 || drops !== 8'd0) begin
            n_err++;
            $display("FAIL swap_pulse: got swap=%b busy=%b drops=%0d, want 1 0 0", swap, busy, drops);
        end
        $display("swap: swap=%b busy=%b", swap, busy);
        trigger = 1'b1; state_in = 64'h1234;
        step();
        trigger = 1'b0;
        n_cmp++;
        if (swap !== 1'b0 || tvalid !== 1'b1 || tdata !== {9'd0, 64'h1234} || drops !== 8'd0) begin
            n_err++;
            $display("FAIL swap_retrigger: got swap=%b v=%b data=%h drops=%0d, want 0 1 %h 0",
                     swap, tvalid, tdata, drops, {9'd0, 64'h1234});
        end
    endtask

    task automatic test_stall();
        logic [COL_W+STATE_W-1:0] exp;
        step();
        tready = 1'b0; state_in = 64'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (tvalid !== 1'b1 || tdata !== {9'd1, 64'h1234} || tlast !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: got v=%b data=%h last=%b, want 1 %h 0",
                         i, tvalid, tdata, tlast, {9'd1, 64'h1234});
            end
            $display("stall: cycle %0d data=%h", i, tdata);
        end
        tready = 1'b1;
        for (int c = 2; c < N_COLS; c++) begin
            step();
            exp = {c[COL_W-1:0], 64'h1234};
            n_cmp++;
            if (tvalid !== 1'b1 || tdata !== exp || tlast !== (c == N_COLS - 1)) begin
                n_err++;
                $display("FAIL stall_beat%0d: got v=%b data=%h last=%b, want 1 %h %b",
                         c, tvalid, tdata, tlast, exp, (c == N_COLS - 1));
            end
            $display("stall: beat col=%0d data=%h", c, tdata);
        end
        step();
        n_cmp++;
        if (tvalid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_end: got tvalid=%b busy=%b, want 0 1", tvalid, busy);
        end
    endtask

    task automatic test_drops();
        bit saw_timeout = 0;
        bit saw_swap = 0;
        for (int i = 0; i < 3; i++) begin
            trigger = 1'b1; step();
            trigger = 1'b0; step();
        end
        n_cmp++;
        if (drops !== 8'd3) begin
            n_err++;
            $display("FAIL drops_three: got %0d, want 3", drops);
        end
        $display("drops: count=%0d", drops);
        for (int i = 0; i < 30 && !saw_timeout; i++) begin
            step();
            if (swap) saw_swap = 1;
            if (timeout) saw_timeout = 1;
        end
        n_cmp++;
        if (!saw_timeout || saw_swap || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drops_frame_timeout: got timeout_seen=%b swap_seen=%b busy=%b, want 1 0 0",
                     saw_timeout, saw_swap, busy);
        end
    endtask

    task automatic test_timeout();
        bit early = 0;
        trigger = 1'b1; state_in = 64'h55;
        step();
        trigger = 1'b0;
        for (int i = 0; i < N_COLS; i++) step();
        n_cmp++;
        if (tvalid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_enter: got tvalid=%b busy=%b, want 0 1", tvalid, busy);
        end
        for (int k = 1; k < TMO; k++) begin
            step();
            if (timeout || swap || !busy) early = 1;
        end
        n_cmp++;
        if (early) begin
            n_err++;
            $display("FAIL timeout_early: got early event=1, want 0");
        end
        step();
        n_cmp++;
        if (timeout !== 1'b1 || busy !== 1'b0 || swap !== 1'b0 || drops !== 8'd3) begin
            n_err++;
            $display("FAIL timeout_pulse: got t=%b busy=%b swap=%b drops=%0d, want 1 0 0 3",
                     timeout, busy, swap, drops);
        end
        $display("timeout: pulse=%b busy=%b", timeout, busy);
        step();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_width: got %b, want 0", timeout);
        end
    endtask

    task automatic test_saturate();
        trigger = 1'b1;
        for (int i = 0; i < 300; i++) step();
        trigger = 1'b0;
        n_cmp++;
        if (drops !== 8'd255) begin
            n_err++;
            $display("FAIL drops_saturate: got %0d, want 255", drops);
        end
        step();
        n_cmp++;
        if (drops !== 8'd255) begin
            n_err++;
            $display("FAIL drops_hold: got %0d, want 255", drops);
        end
        $display("saturate: count=%0d", drops);
    endtask

    task automatic test_async_reset();
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++;
        if (drops !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_clear: got drops=%0d busy=%b, want 0 0", drops, busy);
        end
        trigger = 1'b1; state_in = 64'h77;
        step();
        trigger = 1'b0;
        step(); step();
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== {9'd2, 64'h77}) begin
            n_err++;
            $display("FAIL rst_pre_col2: got v=%b data=%h, want 1 %h", tvalid, tdata, {9'd2, 64'h77});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || swap !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: got v=%b busy=%b swap=%b, want 0 0 0", tvalid, busy, swap);
        end
        #2 rst = 1'b0;
        step();
        trigger = 1'b1; state_in = 64'h88;
        step();
        trigger = 1'b0;
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== {9'd0, 64'h88} || tlast !== 1'b0) begin
            n_err++;
            $display("FAIL rst_restart: got v=%b data=%h last=%b, want 1 %h 0",
                     tvalid, tdata, tlast, {9'd0, 64'h88});
        end
        $display("async_reset: restart data=%h", tdata);
    endtask

    initial begin
        test_reset();
        test_issue();
        test_swap();
        test_stall();
        test_drops();
        test_timeout();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no completion, want finish");
        $fatal(1, "time limit");
    end

endmodule
